dma_copy_master: RTL and testbench

Single-channel bus-master copy engine that sits directly upstream of the system BUS on its master port. On a start pulse it requests the bus, then copies a block of 64-bit words from a source address range to a destination address range through the BUS slaves (s0/s1 space). Each word is a bus read followed by a bus write. It reports completion with a one-cycle done pulse.

---
 rtl/dma_copy_master.sv | 161 ++++++++++++++++
 tb/tb_dma_copy_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy_master.sv
// dma_copy_master: single-channel bus-master block copy engine.
// Each word is one bus read (RD + CAP) followed by one bus write (WR).
// Optional build macro DMA_FILL_EN adds a fill mode that writes fill_data
// to len consecutive destination words without reading.
module dma_copy_master (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] len,
`ifdef DMA_FILL_EN
  input  logic        fill,
  input  logic [63:0] fill_data,
`endif
  output logic        busy,
  output logic        done,
  output logic        m_req,
  input  logic        m_grant,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic [63:0] m_din
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [AW-1:0] remain_q, remain_d;
  logic [DW-1:0] data_buf_q, data_buf_d;
  logic          fill_mode;
  logic [DW-1:0] wr_data;

`ifdef DMA_FILL_EN
  logic          fill_q, fill_d;
  logic [DW-1:0] fill_data_q, fill_data_d;

  // Fill-mode configuration registers, latched at start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else begin
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
    end
  end

  assign fill_mode = fill_q;
  assign wr_data   = fill_q ? fill_data_q : data_buf_q;
`else
  assign fill_mode = 1'b0;
  assign wr_data   = data_buf_q;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      remain_q   <= '0;
      data_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      remain_q   <= remain_d;
      data_buf_q <= data_buf_d;
    end
  end

  // Next-state logic and bus outputs decoded from registered state
  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    remain_d   = remain_q;
    data_buf_d = data_buf_q;
`ifdef DMA_FILL_EN
    fill_d      = fill_q;
    fill_data_d = fill_data_q;
`endif
    busy   = 1'b0;
    done   = 1'b0;
    m_req  = 1'b0;
    m_wr   = 1'b0;
    m_addr = '0;
    m_dout = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          remain_d  = len;
`ifdef DMA_FILL_EN
          fill_d      = fill;
          fill_data_d = fill_data;
`endif
          state_d = (len == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        busy  = 1'b1;
        m_req = 1'b1;
        if (m_grant) state_d = fill_mode ? S_WR : S_RD;
      end
      S_RD: begin
        busy   = 1'b1;
        m_req  = 1'b1;
        m_addr = src_ptr_q;
        if (m_grant) state_d = S_CAP;
      end
      S_CAP: begin
        busy   = 1'b1;
        m_req  = 1'b1;
        m_addr = src_ptr_q;
        // Read data is only trusted while the bus is still ours
        if (m_grant) begin
          data_buf_d = m_din;
          state_d    = S_WR;
        end else begin
          state_d = S_RD;
        end
      end
      S_WR: begin
        busy   = 1'b1;
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = dst_ptr_q;
        m_dout = wr_data;
        if (m_grant) begin
          src_ptr_d = src_ptr_q + AW'(1);
          dst_ptr_d = dst_ptr_q + AW'(1);
          remain_d  = remain_q - AW'(1);
          if (remain_q == AW'(1)) state_d = S_DONE;
          else                    state_d = fill_mode ? S_WR : S_RD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_copy_master.sv
// tb_dma_copy_master: scoreboard bench for dma_copy_master. A bus memory model
// serves the DUT; expected writes are computed from a reference memory and
// queued at job issue, and a monitor pops and compares on every bus write.
`timescale 1ns/1ps
module tb_dma_copy_master;

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, m_req, m_wr;
  logic        m_grant = 1'b1;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic [63:0] m_din = '0;

  logic [63:0] mem       [0:65535];
  logic [63:0] model_mem [0:65535];
  wr_t         exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  int done_cyc = 0;
  bit gmode_rand = 1'b0;

  dma_copy_master dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
`ifdef DMA_FILL_EN
    .fill     (1'b0),
    .fill_data(64'h0),
`endif
    .busy     (busy),
    .done     (done),
    .m_req    (m_req),
    .m_grant  (m_grant),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_dout   (m_dout),
    .m_din    (m_din)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_word(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, 16'hC0DE};
  endfunction

  function automatic logic [63:0] preload(input logic [15:0] a);
    logic [63:0] v;
    v = init_word(a);
    if (a < 16'd4) v = 64'h11 * (64'(a) + 64'd1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Bus slave memory: registered read data, garbage when the read had no grant
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = preload(16'(a));
    forever begin
      @(posedge clk);
      if (m_req && m_grant && m_wr) mem[m_addr] <= m_dout;
      m_din <= (m_req && m_grant && !m_wr) ? mem[m_addr] : {32'hBAD0BAD0, 32'($urandom)};
    end
  end

  // Monitor: scoreboard pop on every committed write, done/idle-bus checks
  initial begin
    logic prev_done;
    wr_t  e;
    prev_done = 1'b0;
    for (int a = 0; a < 65536; a++) model_mem[a] = preload(16'(a));
    forever begin
      @(negedge clk);
      #1;
      if (reset_n) begin
        if (!m_wr) chk("m_dout_not_wr", m_dout, 64'h0);
        if (m_req) req_cnt++;
        if (m_req && m_wr && m_grant) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %h data %h", m_addr, m_dout);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(m_addr), 64'(e.addr));
            chk("wr_data", m_dout, e.data);
            model_mem[e.addr] = e.data;
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_single_cycle", 64'(prev_done), 64'h0);
        end
        prev_done = done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (gmode_rand) m_grant = ($urandom_range(0, 3) != 0);
  endtask

  // Issue one copy and wait for done; expected writes come from the reference memory
  task automatic run_job(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                         input bit lat_chk, input int lat_extra, input int drop_word, input bit poke);
    int base_done, base_wr, base_req, st_edge, waited, drop_state;
    for (int i = 0; i < int'(n); i++)
      exp_q.push_back('{addr: 16'(d + 16'(i)), data: model_mem[16'(s + 16'(i))]});
    base_done = done_cnt;
    base_wr   = wr_cnt;
    base_req  = req_cnt;
    step();
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    st_edge  = cyc + 1;
    step();
    start = 1'b0;
    src_addr = 16'($urandom); dst_addr = 16'($urandom); len = 16'($urandom);
    #1;
    if (n == 16'd0) begin
      chk("zero_len_done", 64'(done), 64'h1);
      chk("zero_len_no_req", 64'(m_req), 64'h0);
    end else begin
      chk("busy_after_start", 64'(busy), 64'h1);
      chk("req_after_start", 64'(m_req), 64'h1);
    end
    waited = 0;
    drop_state = 0;
    while (done_cnt == base_done && waited < 3000) begin
      step();
      if (drop_state == 1 || drop_state == 2) begin
        m_grant = 1'b0;
        drop_state++;
      end else if (drop_state == 3) begin
        m_grant = 1'b1;
        drop_state++;
      end
      if (poke && waited == 3) begin
        start = 1'b1; len = 16'd7;
      end else begin
        start = 1'b0;
      end
      #2;
      if (drop_word >= 0 && drop_state == 0 && m_req && !m_wr && m_addr == 16'(s + 16'(drop_word)))
        drop_state = 1;
      waited++;
    end
    start = 1'b0;
    if (waited >= 3000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, len %0d", waited, n);
    end
    step();
    step();
    #2;
    chk("write_count", 64'(wr_cnt - base_wr), 64'(n));
    chk("done_count", 64'(done_cnt - base_done), 64'h1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    if (n == 16'd0) chk("zero_len_req_cycles", 64'(req_cnt - base_req), 64'h0);
    if (lat_chk)
      chk("done_latency", 64'(done_cyc - st_edge),
          (n == 16'd0) ? 64'h0 : 64'(1 + 3 * int'(n) + lat_extra));
  endtask

  initial begin
    logic [15:0] s, d, n;
    int base_wr, base_done;
    bit found;

    // Reset asserted with start high: everything quiet
    start = 1'b1;
    len   = 16'd5;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_m_req", 64'(m_req), 64'h0);
    chk("rst_m_wr", 64'(m_wr), 64'h0);
    chk("rst_m_addr", 64'(m_addr), 64'h0);
    chk("rst_m_dout", m_dout, 64'h0);
    start = 1'b0;
    len   = '0;
    step();
    reset_n = 1'b1;
    step();

    // Basic copy with latency check
    run_job(16'h0000, 16'h0100, 16'd4, 1'b1, 0, -1, 1'b0);
    for (int i = 0; i < 4; i++)
      chk("copy_dst_word", mem[16'h0100 + i], 64'h11 * 64'(i + 1));

    // Zero length
    run_job(16'h0050, 16'h0600, 16'd0, 1'b1, 0, -1, 1'b0);

    // Address wrap on the source side
    run_job(16'hFFFF, 16'h0200, 16'd2, 1'b1, 0, -1, 1'b0);
    chk("wrap_dst0", mem[16'h0200], init_word(16'hFFFF));
    chk("wrap_dst1", mem[16'h0201], 64'h11);

    // Grant dropped for two cycles starting in CAP of word 1: word re-read
    run_job(16'h0010, 16'h0300, 16'd3, 1'b1, 3, 1, 1'b0);

    // Reset during WR of word 2 of a 4-word copy
    s = 16'h0020;
    d = 16'h0400;
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{addr: 16'(d + 16'(i)), data: model_mem[16'(s + 16'(i))]});
    base_wr   = wr_cnt;
    base_done = done_cnt;
    step();
    src_addr = s; dst_addr = d; len = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      #2;
      if (m_req && !m_wr && m_addr == 16'(s + 16'd2)) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL rst_mid_timeout: word 2 read never seen");
    end
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_m_req", 64'(m_req), 64'h0);
    chk("midrst_m_wr", 64'(m_wr), 64'h0);
    chk("midrst_m_addr", 64'(m_addr), 64'h0);
    repeat (3) step();
    chk("midrst_no_done", 64'(done_cnt - base_done), 64'h0);
    chk("midrst_writes", 64'(wr_cnt - base_wr), 64'h2);
    exp_q.delete();
    reset_n = 1'b1;
    step();
    run_job(16'h0030, 16'h0500, 16'd1, 1'b1, 0, -1, 1'b0);

    // Randomized jobs with random grant behaviour
    gmode_rand = 1'b1;
    for (int j = 0; j < 12; j++) begin
      s = 16'($urandom);
      d = 16'(s + 16'h4000 + 16'($urandom_range(0, 16'h7FFF)));
      n = (j % 5 == 4) ? 16'd0 : 16'($urandom_range(1, 12));
      run_job(s, d, n, 1'b0, 0, -1, (j == 3 && n >= 16'd3));
    end
    gmode_rand = 1'b0;
    m_grant = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
